// File: rtl/imem_loader.sv
// Writable DEPTH x DW instruction store with a byte-serial, strobe-driven loader.
// The core fetches combinationally by PC and may only advance while cpu_run is high.
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic          run_req,
  input  logic          wr_strobe,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_instr,
  output logic          cpu_run,
  output logic          load_busy,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic          err_stray
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] COUNT_LAST = (AW+1)'(DEPTH - 1);

  state_t state, state_next;

  logic [DW-1:0] mem [DEPTH];

  logic s1, s2, s3;
  logic strobe_edge;
  logic wr_en;
  logic enter_load;

  assign strobe_edge = s2 & ~s3;
  assign wr_en       = (state == LOAD) && strobe_edge;
  assign enter_load  = (state != LOAD) && (state_next == LOAD);
  assign fetch_instr = mem[fetch_addr];

  // Synchronise the asynchronous pin strobe and keep a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= wr_strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Program store: not reset, so contents survive rst; reads see new data after the clock.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_count[AW-1:0]] <= wr_data;
    end
  end

  // Next-state logic; LOAD ignores requests and only exits on the final word.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (load_req) begin
          state_next = LOAD;
        end else if (run_req) begin
          state_next = RUN;
        end
      end
      LOAD: begin
        if (strobe_edge && (load_count == COUNT_LAST)) begin
          state_next = DONE;
        end
      end
      DONE: state_next = RUN;
      RUN: begin
        if (load_req) begin
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_run    <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_count <= '0;
      err_stray  <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_run   <= (state_next == RUN);
      load_busy <= (state_next == LOAD);
      load_done <= (state_next == DONE);

      if (enter_load) begin
        load_count <= '0;
      end else if (wr_en && (load_count != COUNT_FULL)) begin
        load_count <= load_count + 1'b1;
      end

      // Starting a load clears the flag even if a stray edge lands in the same cycle.
      if (enter_load) begin
        err_stray <= 1'b0;
      end else if (strobe_edge && (state != LOAD)) begin
        err_stray <= 1'b1;
      end
    end
  end

endmodule
